// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution unit.
// Resolves conditional branches, produces the registered redirect PC and the
// misprediction flag, owns the 2-bit-counter BHT that fetch reads, and keeps
// saturating branch/mispredict counters.
//
// Valid semantics: there is no back-pressure. An op is accepted on any rising
// edge where e_valid=1 and flush=0, and its result is presented for exactly
// one cycle with r_valid=1 on the following cycle.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             e_valid,
    input  logic [2:0]       e_bctrl,
    input  logic [XLEN-1:0]  e_rs1,
    input  logic [XLEN-1:0]  e_rs2,
    input  logic [XLEN-1:0]  e_pc,
    input  logic [XLEN-1:0]  e_imm,
    input  logic             e_pred_taken,
    input  logic             flush,
    output logic             r_valid,
    output logic             r_taken,
    output logic             r_mispredict,
    output logic [XLEN-1:0]  r_redirect_pc,
    output logic             r_illegal,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispred
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // funct3 encodings of the conditional branches
    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] e_idx;
    logic             cond;
    logic             legal;
    logic             accept;
    logic             update;
    logic             mispred;

    // PC bits above and below the index field do not take part in the lookup
    logic unused_fpc_bits;
    assign unused_fpc_bits = ^{f_pc[XLEN-1:2+IDX_W], f_pc[1:0]};

    assign f_idx        = f_pc[2 +: IDX_W];
    assign e_idx        = e_pc[2 +: IDX_W];
    assign f_pred_taken = bht[f_idx][1];

    // 010 and 011 are the only unused funct3 codes in the branch space
    assign legal   = (e_bctrl[2:1] != 2'b01);
    assign accept  = e_valid & ~flush;
    assign update  = accept & legal;
    assign mispred = cond ^ e_pred_taken;

    // Branch condition evaluation
    always_comb begin
        cond = 1'b0;
        case (e_bctrl)
            F_BEQ:   cond = (e_rs1 == e_rs2);
            F_BNE:   cond = (e_rs1 != e_rs2);
            F_BLT:   cond = ($signed(e_rs1) <  $signed(e_rs2));
            F_BGE:   cond = ($signed(e_rs1) >= $signed(e_rs2));
            F_BLTU:  cond = (e_rs1 <  e_rs2);
            F_BGEU:  cond = (e_rs1 >= e_rs2);
            default: cond = 1'b0;
        endcase
    end

    // Registered result stage; redirect PC holds when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_illegal     <= 1'b0;
            r_redirect_pc <= '0;
        end else if (accept) begin
            r_valid       <= 1'b1;
            r_illegal     <= ~legal;
            r_taken       <= legal & cond;
            r_mispredict  <= legal & mispred;
            r_redirect_pc <= (legal && cond) ? (e_pc + e_imm) : (e_pc + XLEN'(4));
        end else begin
            r_valid       <= 1'b0;
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_illegal     <= 1'b0;
        end
    end

    // BHT: all entries weak not-taken on reset, saturating 2-bit training
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (update) begin
            if (cond) begin
                if (bht[e_idx] != 2'b11) bht[e_idx] <= bht[e_idx] + 2'b01;
            end else begin
                if (bht[e_idx] != 2'b00) bht[e_idx] <= bht[e_idx] - 2'b01;
            end
        end
    end

    // Saturating performance counters for legal accepted branches
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (update) begin
            if (perf_branches != '1) perf_branches <= perf_branches + CNT_W'(1);
            if (mispred && (perf_mispred != '1)) perf_mispred <= perf_mispred + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. A second instance with 4-bit
// counters shares the stimulus so counter saturation is reachable quickly.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        e_valid;
    logic [2:0]  e_bctrl;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_pc;
    logic [31:0] e_imm;
    logic        e_pred_taken;
    logic        flush;
    logic        r_valid;
    logic        r_taken;
    logic        r_mispredict;
    logic [31:0] r_redirect_pc;
    logic        r_illegal;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;

    logic        f_pred_taken4;
    logic        r_valid4;
    logic        r_taken4;
    logic        r_mispredict4;
    logic [31:0] r_redirect_pc4;
    logic        r_illegal4;
    logic [3:0]  perf_branches4;
    logic [3:0]  perf_mispred4;

    int n_checks;
    int n_pass;
    int exp_br;
    int exp_mp;
    logic [31:0] exp_q[$];
    logic [31:0] held_pc;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .e_valid(e_valid), .e_bctrl(e_bctrl), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_pc(e_pc), .e_imm(e_imm), .e_pred_taken(e_pred_taken), .flush(flush),
        .r_valid(r_valid), .r_taken(r_taken), .r_mispredict(r_mispredict),
        .r_redirect_pc(r_redirect_pc), .r_illegal(r_illegal),
        .perf_branches(perf_branches), .perf_mispred(perf_mispred)
    );

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken4),
        .e_valid(e_valid), .e_bctrl(e_bctrl), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_pc(e_pc), .e_imm(e_imm), .e_pred_taken(e_pred_taken), .flush(flush),
        .r_valid(r_valid4), .r_taken(r_taken4), .r_mispredict(r_mispredict4),
        .r_redirect_pc(r_redirect_pc4), .r_illegal(r_illegal4),
        .perf_branches(perf_branches4), .perf_mispred(perf_mispred4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_br = 0;
        exp_mp = 0;
    endtask

    // Fetch-side lookup, evaluated combinationally
    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        f_pc = pc;
        #1;
        check(tag, {63'd0, f_pred_taken}, {63'd0, exp});
    endtask

    // Drive one op onto the execute inputs at the falling edge
    task automatic present(input logic [2:0] ctrl, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                           input logic [31:0] exp_redirect);
        @(negedge clk);
        e_valid      = 1'b1;
        e_bctrl      = ctrl;
        e_rs1        = rs1;
        e_rs2        = rs2;
        e_pc         = pc;
        e_imm        = imm;
        e_pred_taken = pred;
        exp_q.push_back(exp_redirect);
    endtask

    // Clock the op in and compare the registered result
    task automatic retire(input string tag, input logic pred, input logic exp_taken,
                          input logic exp_illegal);
        logic exp_mis;
        exp_mis = exp_illegal ? 1'b0 : (exp_taken ^ pred);
        if (!exp_illegal) begin
            exp_br++;
            if (exp_mis) exp_mp++;
        end
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        check({tag, ".valid"},    {63'd0, r_valid},      64'd1);
        check({tag, ".taken"},    {63'd0, r_taken},      {63'd0, exp_taken});
        check({tag, ".mispred"},  {63'd0, r_mispredict}, {63'd0, exp_mis});
        check({tag, ".illegal"},  {63'd0, r_illegal},    {63'd0, exp_illegal});
        check({tag, ".redirect"}, {32'd0, r_redirect_pc}, {32'd0, exp_q.pop_front()});
        check({tag, ".perf_br"},  {32'd0, perf_branches}, 64'(exp_br));
        check({tag, ".perf_mp"},  {32'd0, perf_mispred},  64'(exp_mp));
    endtask

    task automatic branch(input string tag, input logic [2:0] ctrl, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic exp_taken, input logic exp_illegal,
                          input logic [31:0] exp_redirect);
        present(ctrl, rs1, rs2, pc, imm, pred, exp_redirect);
        retire(tag, pred, exp_taken, exp_illegal);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b0; f_pc = '0; e_valid = 1'b0; e_bctrl = '0; e_rs1 = '0; e_rs2 = '0;
        e_pc = '0; e_imm = '0; e_pred_taken = 1'b0; flush = 1'b0;
        exp_br = 0; exp_mp = 0;

        // Reset state
        do_reset();
        check("rst.valid",   {63'd0, r_valid}, 64'd0);
        check("rst.perf_br", {32'd0, perf_branches}, 64'd0);
        check("rst.perf_mp", {32'd0, perf_mispred}, 64'd0);
        lookup("rst.pred_40", 32'h40, 1'b0);
        lookup("rst.pred_1234", 32'h1234, 1'b0);
        lookup("rst.pred_fc", 32'hFC, 1'b0);

        // Signed vs unsigned compare with the same operands
        branch("blt",  3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 32'h120);
        branch("bltu", 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 32'h104);
        branch("bge",  3'b101, 32'h1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b1, 1'b1, 1'b0, 32'h340);
        branch("bgeu", 3'b111, 32'h1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b1, 1'b0, 1'b0, 32'h304);
        branch("bne",  3'b001, 32'h7, 32'h8, 32'h500, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 32'h4F0);

        // BEQ taken 3x at 0x40; prediction sampled in the execute cycle shows the pre-update value
        present(3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1, 32'h48);
        lookup("beq1.pre", 32'h40, 1'b0);
        retire("beq1", 1'b1, 1'b1, 1'b0);
        lookup("beq1.post", 32'h40, 1'b1);
        present(3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1, 32'h48);
        lookup("beq2.pre", 32'h40, 1'b1);
        retire("beq2", 1'b1, 1'b1, 1'b0);
        present(3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1, 32'h48);
        retire("beq3", 1'b1, 1'b1, 1'b0);
        lookup("beq3.post", 32'h40, 1'b1);
        // Saturated at 11: one not-taken leaves it predicting taken, a second does not
        branch("beq_nt1", 3'b000, 32'h5, 32'h6, 32'h40, 32'h8, 1'b1, 1'b0, 1'b0, 32'h44);
        lookup("beq_nt1.post", 32'h40, 1'b1);
        branch("beq_nt2", 3'b000, 32'h5, 32'h6, 32'h40, 32'h8, 1'b1, 1'b0, 1'b0, 32'h44);
        lookup("beq_nt2.post", 32'h40, 1'b0);
        held_pc = 32'h44;

        // Flush beats e_valid: no result, no count, no training
        @(negedge clk);
        e_valid = 1'b1; flush = 1'b1;
        e_bctrl = 3'b000; e_rs1 = 32'h1; e_rs2 = 32'h1; e_pc = 32'h40; e_imm = 32'h8;
        e_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        e_valid = 1'b0; flush = 1'b0;
        check("flush.valid",    {63'd0, r_valid}, 64'd0);
        check("flush.taken",    {63'd0, r_taken}, 64'd0);
        check("flush.redirect", {32'd0, r_redirect_pc}, {32'd0, held_pc});
        check("flush.perf_br",  {32'd0, perf_branches}, 64'(exp_br));
        lookup("flush.pred_40", 32'h40, 1'b0);

        // Illegal funct3 codes; equal operands would train 0x40 if treated as BEQ
        branch("ill010", 3'b010, 32'h9, 32'h9, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h44);
        branch("ill011", 3'b011, 32'h9, 32'h9, 32'h40, 32'h100, 1'b0, 1'b0, 1'b1, 32'h44);
        lookup("ill.pred_40", 32'h40, 1'b0);

        // Redirect wraps modulo 2^32
        branch("wrap_nt", 3'b000, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        branch("wrap_t",  3'b001, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1, 1'b0, 32'h10);

        // 17 mispredicted branches: 4-bit counters saturate at 15
        for (int i = 0; i < 17; i++) begin
            branch("mp_loop", 3'b000, 32'h0, 32'h0, 32'h80, 32'h4, 1'b0, 1'b1, 1'b0, 32'h84);
        end
        check("sat4.perf_br", {60'd0, perf_branches4}, 64'd15);
        check("sat4.perf_mp", {60'd0, perf_mispred4},  64'd15);
        lookup("mp_loop.pred_80", 32'h80, 1'b1);

        // Reset mid-stream drops the in-flight op and restores the BHT
        @(negedge clk);
        e_valid = 1'b1; e_bctrl = 3'b000; e_rs1 = 32'h0; e_rs2 = 32'h0;
        e_pc = 32'h80; e_imm = 32'h4; e_pred_taken = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        e_valid = 1'b0; rst = 1'b0;
        exp_br = 0; exp_mp = 0;
        check("mid_rst.valid",    {63'd0, r_valid}, 64'd0);
        check("mid_rst.redirect", {32'd0, r_redirect_pc}, 64'd0);
        check("mid_rst.perf_br",  {32'd0, perf_branches}, 64'd0);
        check("mid_rst.perf_mp4", {60'd0, perf_mispred4}, 64'd0);
        lookup("mid_rst.pred_80", 32'h80, 1'b0);

        // Back to normal operation after reset
        branch("post_rst", 3'b100, 32'h3, 32'h4, 32'h80, 32'h10, 1'b1, 1'b1, 1'b0, 32'h90);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
